// File: rtl/fm_modulate_if.sv
// AXI-Stream beat bundle shared by the sample input and the polar-format output of fm_modulate.
// The master side drives valid/data/strobe/last and the slave side drives ready.
interface fm_modulate_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic                    tvalid;
  logic                    tready;
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic                    tlast;

  modport master (output tvalid, tdata, tstrb, tlast, input tready);
  modport slave  (input tvalid, tdata, tstrb, tlast, output tready);
endinterface

// File: rtl/fm_modulate.sv
// FM modulator: integrates scaled audio samples plus a carrier offset into a 32-bit phase
// accumulator and emits {angle, magnitude} beats through a two-stage skid-free AXIS pipeline.
module fm_modulate #(
  parameter int          C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int          C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int          DEV_SHIFT              = 12,
  parameter logic [31:0] CARRIER_INC            = 32'h0,
  parameter logic [15:0] MAG                    = 16'h7FFF,
  parameter bit          PHASE_RESET_ON_LAST    = 1'b0
) (
  input logic          s00_axis_aclk,
  input logic          s00_axis_areset,
  fm_modulate_if.slave  s00_axis,
  fm_modulate_if.master m00_axis
);
  localparam int S_STRB = C_S00_AXIS_TDATA_WIDTH / 8;
  localparam int M_STRB = C_M00_AXIS_TDATA_WIDTH / 8;

  logic                              s1_valid_reg;
  logic [31:0]                       s1_inc_reg;
  logic                              s1_last_reg;
  logic [S_STRB-1:0]                 s1_strb_reg;
  logic [31:0]                       acc_reg;
  logic                              tvalid_reg;
  logic [C_M00_AXIS_TDATA_WIDTH-1:0] tdata_reg;
  logic                              tlast_reg;
  logic [M_STRB-1:0]                 tstrb_reg;

  logic        out_free;
  logic        s1_move;
  logic        accept;
  logic [31:0] sample_ext;
  logic [31:0] inc_next;
  logic [31:0] acc_next;
  logic        unused_upper;

  assign out_free = ~tvalid_reg | m00_axis.tready;
  assign s1_move  = s1_valid_reg & out_free;
  assign accept   = s00_axis.tvalid & s00_axis.tready;

  assign s00_axis.tready = ~s1_valid_reg | out_free;

  // Shifted sample bits beyond bit 31 fall off; the sum wraps mod 2^32.
  assign sample_ext = {{16{s00_axis.tdata[15]}}, s00_axis.tdata[15:0]};
  assign inc_next   = CARRIER_INC + (sample_ext << DEV_SHIFT);
  assign acc_next   = acc_reg + s1_inc_reg;

  assign unused_upper = ^s00_axis.tdata[C_S00_AXIS_TDATA_WIDTH-1:16];

  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      s1_valid_reg <= 1'b0;
      s1_inc_reg   <= '0;
      s1_last_reg  <= 1'b0;
      s1_strb_reg  <= '0;
      acc_reg      <= '0;
      tvalid_reg   <= 1'b0;
      tdata_reg    <= '0;
      tlast_reg    <= 1'b0;
      tstrb_reg    <= '0;
    end else begin
      if (accept) begin
        s1_valid_reg <= 1'b1;
        s1_inc_reg   <= inc_next;
        s1_last_reg  <= s00_axis.tlast;
        s1_strb_reg  <= s00_axis.tstrb;
      end else if (s1_move) begin
        s1_valid_reg <= 1'b0;
      end

      if (s1_move) begin
        // Packet-aligned phase restart: the tlast beat still reports acc_next.
        acc_reg    <= (PHASE_RESET_ON_LAST && s1_last_reg) ? 32'h0 : acc_next;
        tdata_reg  <= C_M00_AXIS_TDATA_WIDTH'({acc_next[31:16], MAG});
        tlast_reg  <= s1_last_reg;
        tstrb_reg  <= M_STRB'(s1_strb_reg);
        tvalid_reg <= 1'b1;
      end else if (m00_axis.tready && tvalid_reg) begin
        tvalid_reg <= 1'b0;
      end
    end
  end

  assign m00_axis.tvalid = tvalid_reg;
  assign m00_axis.tdata  = tdata_reg;
  assign m00_axis.tlast  = tlast_reg;
  assign m00_axis.tstrb  = tstrb_reg;
endmodule

// File: tb/tb_fm_modulate.sv
// Scoreboard bench for fm_modulate: three parameterisations share one input stream and
// output-ready pattern; a phase-accumulator model predicts each beat at accept time.
module tb_fm_modulate;
  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_sample;
  logic [15:0] in_junk;
  logic        in_last;
  logic [3:0]  in_strb;
  logic        out_rdy;

  fm_modulate_if #(.DATA_WIDTH(32)) s0 ();
  fm_modulate_if #(.DATA_WIDTH(32)) s1 ();
  fm_modulate_if #(.DATA_WIDTH(32)) s2 ();
  fm_modulate_if #(.DATA_WIDTH(32)) m0 ();
  fm_modulate_if #(.DATA_WIDTH(32)) m1 ();
  fm_modulate_if #(.DATA_WIDTH(32)) m2 ();

  fm_modulate dut0 (
    .s00_axis_aclk(clk), .s00_axis_areset(rst), .s00_axis(s0), .m00_axis(m0)
  );
  fm_modulate #(.CARRIER_INC(32'h4000_0000)) dut1 (
    .s00_axis_aclk(clk), .s00_axis_areset(rst), .s00_axis(s1), .m00_axis(m1)
  );
  fm_modulate #(.PHASE_RESET_ON_LAST(1'b1)) dut2 (
    .s00_axis_aclk(clk), .s00_axis_areset(rst), .s00_axis(s2), .m00_axis(m2)
  );

  assign s0.tvalid = in_valid; assign s0.tdata = {in_junk, in_sample};
  assign s0.tlast  = in_last;  assign s0.tstrb = in_strb;
  assign s1.tvalid = in_valid; assign s1.tdata = {in_junk, in_sample};
  assign s1.tlast  = in_last;  assign s1.tstrb = in_strb;
  assign s2.tvalid = in_valid; assign s2.tdata = {in_junk, in_sample};
  assign s2.tlast  = in_last;  assign s2.tstrb = in_strb;
  assign m0.tready = out_rdy;
  assign m1.tready = out_rdy;
  assign m2.tready = out_rdy;

  logic        s_rdy  [3];
  logic        m_vld  [3];
  logic [31:0] m_data [3];
  logic        m_last [3];
  logic [3:0]  m_strb [3];

  assign s_rdy[0] = s0.tready; assign s_rdy[1] = s1.tready; assign s_rdy[2] = s2.tready;
  assign m_vld[0] = m0.tvalid; assign m_vld[1] = m1.tvalid; assign m_vld[2] = m2.tvalid;
  assign m_data[0] = m0.tdata; assign m_data[1] = m1.tdata; assign m_data[2] = m2.tdata;
  assign m_last[0] = m0.tlast; assign m_last[1] = m1.tlast; assign m_last[2] = m2.tlast;
  assign m_strb[0] = m0.tstrb; assign m_strb[1] = m1.tstrb; assign m_strb[2] = m2.tstrb;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          first_acc = -1;
  int          first_vld = -1;
  bit          acc_flag;
  logic [36:0] exp_q [3][$];
  logic [15:0] seen  [3][$];
  logic [31:0] acc_m  [3];
  logic        hold_v [3];
  logic [31:0] hold_d [3];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] carrier_of(input int d);
    return (d == 1) ? 32'h4000_0000 : 32'h0;
  endfunction

  // One clock: settle after the negedge drive, score the handshakes about to happen, advance.
  task automatic step();
    logic [36:0] e;
    logic [31:0] inc;
    logic [31:0] sx;
    #1;
    cyc++;
    acc_flag = 1'b0;
    if (rst) begin
      for (int d = 0; d < 3; d++) begin
        exp_q[d].delete();
        acc_m[d]  = 32'h0;
        hold_v[d] = 1'b0;
      end
      first_acc = -1;
      first_vld = -1;
    end else begin
      if (first_acc < 0 && in_valid && s_rdy[0]) first_acc = cyc;
      if (first_vld < 0 && m_vld[0]) first_vld = cyc;
      for (int d = 0; d < 3; d++) begin
        if (hold_v[d]) begin
          chk("hold_tvalid", 64'(m_vld[d]), 64'(1));
          chk("hold_tdata", 64'(m_data[d]), 64'(hold_d[d]));
        end
        hold_v[d] = m_vld[d] && !out_rdy;
        hold_d[d] = m_data[d];
        if (m_vld[d] && out_rdy) begin
          if (exp_q[d].size() == 0) begin
            chk("spurious_beat", 64'(1), 64'(0));
          end else begin
            e = exp_q[d].pop_front();
            chk("tdata", 64'(m_data[d]), 64'(e[36:5]));
            chk("tlast", 64'(m_last[d]), 64'(e[4]));
            chk("tstrb", 64'(m_strb[d]), 64'(e[3:0]));
            seen[d].push_back(m_data[d][31:16]);
            $display("beat dut%0d angle=%04h mag=%04h last=%b strb=%h",
                     d, m_data[d][31:16], m_data[d][15:0], m_last[d], m_strb[d]);
          end
        end
        if (in_valid && s_rdy[d]) begin
          sx  = {{16{in_sample[15]}}, in_sample};
          inc = carrier_of(d) + (sx << 12);
          acc_m[d] = acc_m[d] + inc;
          e = {acc_m[d][31:16], 16'h7FFF, in_last, in_strb};
          if (d == 2 && in_last) acc_m[d] = 32'h0;
          exp_q[d].push_back(e);
          if (d == 0) acc_flag = 1'b1;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic reset_dut();
    rst = 1'b1; in_valid = 1'b0;
    step(); step();
    rst = 1'b0;
    for (int d = 0; d < 3; d++) seen[d].delete();
  endtask

  task automatic send(input logic [15:0] smp, input logic lst, input logic [3:0] stb);
    int n = 0;
    in_valid = 1'b1; in_sample = smp; in_last = lst; in_strb = stb;
    in_junk = 16'($urandom);
    do begin
      step();
      n++;
    end while (!acc_flag && n < 50);
    if (!acc_flag) chk("accept_timeout", 64'(0), 64'(1));
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0; out_rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (exp_q[0].size() == 0 && exp_q[1].size() == 0 && exp_q[2].size() == 0) break;
      step();
    end
    for (int d = 0; d < 3; d++) chk("drain_left", 64'(exp_q[d].size()), 64'(0));
  endtask

  task automatic check_seen(input string tag, input int d, input logic [15:0] want [5],
                            input int n);
    chk({tag, "_count"}, 64'(seen[d].size()), 64'(n));
    for (int i = 0; i < n && i < seen[d].size(); i++)
      chk(tag, 64'(seen[d][i]), 64'(want[i]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] want [5];
    logic [15:0] prev;
    int k;
    rst = 1'b1; in_valid = 1'b0; in_sample = '0; in_junk = '0;
    in_last = 1'b0; in_strb = '0; out_rdy = 1'b1;
    @(negedge clk);

    // Reset state
    reset_dut();
    for (int d = 0; d < 3; d++) begin
      chk("rst_tvalid", 64'(m_vld[d]), 64'(0));
      chk("rst_tready", 64'(s_rdy[d]), 64'(1));
      chk("rst_tdata", 64'(m_data[d]), 64'(0));
      chk("rst_tlast", 64'(m_last[d]), 64'(0));
      chk("rst_tstrb", 64'(m_strb[d]), 64'(0));
    end

    // Positive deviation, back-to-back
    for (int i = 0; i < 5; i++) send(16'h1000, 1'b0, 4'hF);
    drain();
    chk("latency", 64'(first_vld - first_acc), 64'(2));
    want = '{16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500};
    check_seen("pos_angle", 0, want, 5);

    // Negative deviation and demodulator difference
    reset_dut();
    for (int i = 0; i < 3; i++) send(16'hF000, 1'b0, 4'(i + 3));
    drain();
    want = '{16'hFF00, 16'hFE00, 16'hFD00, 16'h0, 16'h0};
    check_seen("neg_angle", 0, want, 3);
    prev = 16'h0;
    for (int i = 0; i < seen[0].size(); i++) begin
      chk("demod_diff", 64'(16'(seen[0][i] - prev)), 64'(16'hFF00));
      prev = seen[0][i];
    end

    // Carrier-only wrap
    reset_dut();
    for (int i = 0; i < 5; i++) send(16'h0000, 1'b0, 4'hA);
    drain();
    want = '{16'h4000, 16'h8000, 16'hC000, 16'h0000, 16'h4000};
    check_seen("wrap_angle", 1, want, 5);

    // Phase restart after tlast
    reset_dut();
    send(16'h1000, 1'b0, 4'hF);
    send(16'h1000, 1'b1, 4'hF);
    send(16'h1000, 1'b0, 4'hF);
    send(16'h1000, 1'b0, 4'hF);
    drain();
    want = '{16'h0100, 16'h0200, 16'h0100, 16'h0200, 16'h0};
    check_seen("plast_angle", 2, want, 4);

    // Backpressure then random ready
    reset_dut();
    out_rdy = 1'b0; in_valid = 1'b1; k = 0;
    for (int i = 0; i < 6; i++) begin
      in_sample = 16'(16'h0100 * (k + 1)); in_strb = 4'(k + 1);
      step();
      if (acc_flag) k++;
    end
    chk("bp_accepts", 64'(k), 64'(2));
    chk("bp_tready", 64'(s_rdy[0]), 64'(0));
    out_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (acc_flag || !in_valid) begin
        in_valid  = 1'($urandom_range(0, 1));
        in_sample = 16'($urandom);
        in_last   = 1'($urandom_range(0, 1));
        in_strb   = 4'($urandom);
      end
      out_rdy = 1'($urandom_range(0, 1));
      step();
    end
    drain();

    // Reset with both stages full
    out_rdy = 1'b0; in_valid = 1'b1; in_sample = 16'h2000;
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("midrst_tvalid", 64'(m_vld[0]), 64'(0));
    chk("midrst_tready", 64'(s_rdy[0]), 64'(1));
    out_rdy = 1'b1;
    for (int d = 0; d < 3; d++) seen[d].delete();
    send(16'h1000, 1'b0, 4'hF);
    drain();
    want = '{16'h0100, 16'h0, 16'h0, 16'h0, 16'h0};
    check_seen("midrst_angle", 0, want, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
